// File: rtl/pipe_mdu.sv
// Iterative multiply/divide unit with HI/LO result registers for an in-order pipeline.
// It uses a shift-add multiply and a restoring divide, one bit per cycle, then one sign-fix cycle.
module pipe_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t           r_state, w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a, r_rem, r_quo, r_hi, r_lo;
    logic             r_is_div, r_neg_q, r_neg_r, r_dz, r_done, r_div_zero;

    logic               w_accept, w_a_neg, w_b_neg, w_ge;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_diff, w_quo_fix, w_rem_fix;
    logic [WIDTH:0]     w_sum, w_shift;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;

    assign w_accept = start && !flush && (r_state == IDLE);

    // op[0] set means the unsigned variant, so operands are taken raw
    assign w_a_neg = !op[0] && inp1[WIDTH-1];
    assign w_b_neg = !op[0] && inp2[WIDTH-1];
    assign w_a_mag = w_a_neg ? -inp1 : inp1;
    assign w_b_mag = w_b_neg ? -inp2 : inp2;

    // Multiply: {r_rem, r_quo} is the product register, multiplier consumed from r_quo[0]
    assign w_sum = {1'b0, r_rem} + {1'b0, r_a & {WIDTH{r_quo[0]}}};

    // Divide: r_rem is the partial remainder, dividend bits shift out of r_quo
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = w_shift >= {1'b0, r_a};
    assign w_diff  = w_shift[WIDTH-1:0] - r_a;

    assign w_prod     = {r_rem, r_quo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -r_quo : r_quo);
    assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !op[2]) begin
                    w_state_next = op[1] ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                if (flush) begin
                    w_state_next = IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = FIX;
                end
            end
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_a        <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (op == 3'b100) begin
                            r_hi <= inp1;
                        end else if (op == 3'b101) begin
                            r_lo <= inp1;
                        end else if (!op[2]) begin
                            r_a      <= w_b_mag;
                            r_quo    <= w_a_mag;
                            r_rem    <= '0;
                            r_cnt    <= CW'(WIDTH - 1);
                            r_is_div <= op[1];
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_dz     <= op[1] && (inp2 == '0);
                        end
                    end
                end
                MUL: begin
                    if (!flush) begin
                        {r_rem, r_quo} <= {w_sum, r_quo[WIDTH-1:1]};
                        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    end
                end
                DIV: begin
                    if (!flush) begin
                        r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_ge};
                        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        r_done     <= 1'b1;
                        r_div_zero <= r_dz;
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            {r_hi, r_lo} <= w_prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign divZero = r_div_zero;
    assign hi      = r_hi;
    assign lo      = r_lo;
endmodule

// File: tb/tb_pipe_mdu.sv
// Scoreboard bench for pipe_mdu: issued MUL/DIV ops push expected HI/LO from a plain-arithmetic
// model, and a monitor pops on each done pulse and otherwise checks that HI/LO hold.
module tb_pipe_mdu;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start, flush;
    logic [2:0]   op;
    logic [W-1:0] inp1, inp2;
    logic         busy, done, divZero;
    logic [W-1:0] hi, lo;

    exp_t         q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           n_checks = 0;
    int           n_err = 0;
    bit           mon_en = 1'b0;

    pipe_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .inp1(inp1), .inp2(inp2),
        .flush(flush), .busy(busy), .done(done), .divZero(divZero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        sa = {{32{a[W-1]}}, a};
        sb = {{32{b[W-1]}}, b};
        e = '0;
        case (o)
            3'd0: begin sp = sa * sb; e.hi = sp[63:32]; e.lo = sp[31:0]; end
            3'd1: begin up = {32'b0, a} * {32'b0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
            default: begin
                if (b == '0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else if (o == 3'd2) begin
                    sp = sa / sb; e.lo = sp[31:0];
                    sp = sa % sb; e.hi = sp[31:0];
                end else begin
                    up = {32'b0, a} / {32'b0, b}; e.lo = up[31:0];
                    up = {32'b0, a} % {32'b0, b}; e.hi = up[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: pop on done, otherwise HI/LO must hold and divZero must be low
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (done) begin
                if (q.size() == 0) begin
                    check(1'b0, "unexpected_done", {hi, lo}, 64'h0);
                end else begin
                    e = q.pop_front();
                    check({hi, lo} == {e.hi, e.lo}, "result_hilo", {hi, lo}, {e.hi, e.lo});
                    check(divZero == e.dz, "divzero", 64'(divZero), 64'(e.dz));
                    m_hi = e.hi;
                    m_lo = e.lo;
                end
            end else begin
                check({hi, lo} == {m_hi, m_lo} && !divZero, "hold",
                      {hi, lo}, {m_hi, m_lo});
            end
        end
    end

    // poke > 0 pulses a MULTU start in that busy cycle, which must be ignored
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int poke);
        int nb;
        @(negedge clk);
        start = 1'b1; op = o; inp1 = a; inp2 = b;
        q.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b0; op = 3'b110;
        nb = 0;
        while (busy && nb < 100) begin
            nb++;
            start = (nb == poke);
            op    = (nb == poke) ? 3'b001 : 3'b110;
            @(negedge clk);
        end
        start = 1'b0;
        check(nb == W + 1, "busy_cycles", 64'(nb), 64'(W + 1));
        check(done == 1'b1, "done_latency", 64'(done), 64'h1);
    endtask

    task automatic mt(input logic [2:0] o, input logic [W-1:0] v, input bit fl);
        @(negedge clk);
        start = 1'b1; op = o; inp1 = v; flush = fl;
        @(posedge clk);
        #1;
        if (!fl) begin
            if (o == 3'b100) m_hi = v;
            else m_lo = v;
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0; op = 3'b110;
        check(!busy && !done, "mt_no_busy_done", {62'b0, busy, done}, 64'h0);
        check({hi, lo} == {m_hi, m_lo}, "mt_value", {hi, lo}, {m_hi, m_lo});
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b110; inp1 = '0; inp2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check({busy, done, divZero} == 3'b000, "reset_flags", {61'b0, busy, done, divZero}, 64'h0);
        check({hi, lo} == 64'h0, "reset_hilo", {hi, lo}, 64'h0);
        mon_en = 1'b1;

        issue(3'd0, 32'hFFFF_FFFD, 32'd7, 0);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        issue(3'd3, 32'd100, 32'd7, 5);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(3'd3, 32'd5, 32'd0, 0);
        // Flush in the done cycle must not disturb committed results
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        issue(3'd0, 32'd1234, 32'hFFFF_FF00, 0);

        // Flush at t0+10 of a divide
        @(negedge clk);
        start = 1'b1; op = 3'd2; inp1 = 32'd1000; inp2 = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'b110;
        repeat (9) @(negedge clk);
        check(busy == 1'b1, "busy_before_flush", 64'(busy), 64'h1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check(busy == 1'b0, "busy_after_flush", 64'(busy), 64'h0);
        repeat (W + 5) @(negedge clk);

        mt(3'b100, 32'h1234, 1'b0);
        mt(3'b101, 32'hDEAD_BEEF, 1'b1);
        mt(3'b101, 32'hABCD, 1'b0);

        // Reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = 3'd0; inp1 = 32'd99; inp2 = 32'd77;
        @(negedge clk);
        start = 1'b0; op = 3'b110;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        check({hi, lo} == 64'h0 && !busy && !done, "reset_mid_mul",
              {hi, lo}, 64'h0);
        repeat (W + 5) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 3)), pick(), pick(), 0);
        end

        repeat (5) @(negedge clk);
        check(q.size() == 0, "queue_drained", 64'(q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
